// File: rtl/force_ring_inject_arbiter_pkg.sv
// Shared types and system defaults for the force-output-ring injection arbiter.
package force_ring_inject_arbiter_pkg;

   localparam int FRC_INJ_NUM_REQ      = 4;
   localparam int FRC_INJ_QUIET_CYCLES = 16;

   typedef struct packed {
      logic [7:0]  cid;
      logic [7:0]  parid;
      logic [31:0] force_val;
   } frc_pkt_t;

   localparam int FRC_PKT_STRUCT_WIDTH = $bits(frc_pkt_t);

   typedef enum logic [1:0] {
      INJ_IDLE   = 2'd0,
      INJ_ACTIVE = 2'd1,
      INJ_DRAIN  = 2'd2,
      INJ_DONE   = 2'd3
   } inj_state_t;

endpackage

// File: rtl/force_ring_inject_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after ptr.
module rr_arbiter #(
   parameter int N = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] grant_idx,
   output logic          any
);

   int  j;
   logic hit;

   // Scan from the pointer with wrap-around; the first hit claims the grant.
   always_comb begin
      grant     = {N{1'b0}};
      grant_idx = {PW{1'b0}};
      any       = 1'b0;
      j         = 0;
      hit       = 1'b0;
      for (int i = 0; i < N; i++) begin
         j         = int'(ptr) + i;
         j         = (j >= N) ? (j - N) : j;
         hit       = req[j] & ~any;
         grant[j]  = grant[j] | hit;
         grant_idx = hit ? PW'(j) : grant_idx;
         any       = any | hit;
      end
   end

endmodule

// File: rtl/force_ring_inject_arbiter.sv
// Round-robin injection of PE force packets into one force-output-ring node, with phase FSM.
// Optional build macro FORCE_INJ_STATS_EN adds o_inj_count (packets injected this phase).
module force_ring_inject_arbiter
   import force_ring_inject_arbiter_pkg::*;
#(
   parameter int NUM_REQ            = FRC_INJ_NUM_REQ,
   parameter int DRAIN_QUIET_CYCLES = FRC_INJ_QUIET_CYCLES
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    i_phase_start,
   input  logic [NUM_REQ-1:0]                      i_req_valid,
   input  logic [NUM_REQ*FRC_PKT_STRUCT_WIDTH-1:0] i_req_pkt,
   input  logic [NUM_REQ-1:0]                      i_req_done,
   output logic [NUM_REQ-1:0]                      o_req_ready,
   output logic [FRC_PKT_STRUCT_WIDTH-1:0]         o_inj_pkt,
   output logic                                    o_inj_valid,
   input  logic                                    i_ring_full,
   input  logic                                    i_ring_all_empty,
   output logic                                    o_busy,
   output logic                                    o_phase_done
`ifdef FORCE_INJ_STATS_EN
   ,
   output logic [31:0]                             o_inj_count
`endif
);

   localparam int W  = FRC_PKT_STRUCT_WIDTH;
   localparam int PW = $clog2(NUM_REQ);
   localparam int QW = $clog2(DRAIN_QUIET_CYCLES + 1);
   localparam logic [QW-1:0] QMAX = QW'(DRAIN_QUIET_CYCLES);

   localparam logic [1:0] S_IDLE   = INJ_IDLE;
   localparam logic [1:0] S_ACTIVE = INJ_ACTIVE;
   localparam logic [1:0] S_DRAIN  = INJ_DRAIN;
   localparam logic [1:0] S_DONE   = INJ_DONE;

   logic [1:0]         state_r, state_next;
   logic [PW-1:0]      ptr_r, ptr_next;
   logic [NUM_REQ-1:0] done_r;
   logic [QW-1:0]      quiet_r;
   logic [W-1:0]       inj_pkt_r;
   logic               inj_valid_r;
   logic               arb_en, start, xfer, quiet_cond;
   logic [NUM_REQ-1:0] arb_req, grant;
   logic [PW-1:0]      grant_idx;
   logic               grant_any;

   assign arb_en     = (state_r == S_ACTIVE) || (state_r == S_DRAIN);
   assign arb_req    = arb_en ? i_req_valid : {NUM_REQ{1'b0}};
   assign start      = (state_r == S_IDLE) & i_phase_start;
   assign xfer       = grant_any & ~i_ring_full;
   assign quiet_cond = i_ring_all_empty & ~inj_valid_r & ~(|i_req_valid);
   assign ptr_next   = (grant_idx == PW'(NUM_REQ - 1)) ? {PW{1'b0}} : (grant_idx + PW'(1));

   rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
      .req       (arb_req),
      .ptr       (ptr_r),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (grant_any)
   );

   // Ring full suppresses the grant; the packet already registered still goes out.
   assign o_req_ready  = grant & {NUM_REQ{~i_ring_full}};
   assign o_inj_pkt    = inj_pkt_r;
   assign o_inj_valid  = inj_valid_r;
   assign o_busy       = (state_r != S_IDLE);
   assign o_phase_done = (state_r == S_DONE);

   // Phase sequencing: wait for every PE's done flag, then for sustained ring quiescence.
   always_comb begin
      state_next = state_r;
      case (state_r)
         S_IDLE:   state_next = start ? S_ACTIVE : S_IDLE;
         S_ACTIVE: state_next = ((&done_r) && !(|i_req_valid)) ? S_DRAIN : S_ACTIVE;
         S_DRAIN:  state_next = (quiet_r == QMAX) ? S_DONE : S_DRAIN;
         S_DONE:   state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // State, pointer, done flags, quiet counter and output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_IDLE;
         ptr_r       <= {PW{1'b0}};
         done_r      <= {NUM_REQ{1'b0}};
         quiet_r     <= {QW{1'b0}};
         inj_pkt_r   <= {W{1'b0}};
         inj_valid_r <= 1'b0;
      end else begin
         state_r     <= state_next;
         ptr_r       <= xfer ? ptr_next : ptr_r;
         done_r      <= start ? {NUM_REQ{1'b0}} : (done_r | i_req_done);
         inj_valid_r <= xfer;
         inj_pkt_r   <= xfer ? i_req_pkt[grant_idx*W +: W] : inj_pkt_r;
         if (state_r != S_DRAIN || !quiet_cond) begin
            quiet_r <= {QW{1'b0}};
         end else if (quiet_r != QMAX) begin
            quiet_r <= quiet_r + QW'(1);
         end else begin
            quiet_r <= quiet_r;
         end
      end
   end

`ifdef FORCE_INJ_STATS_EN
   logic [31:0] inj_count_r;

   // Packets actually presented to the ring during the current phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         inj_count_r <= 32'd0;
      end else if (start) begin
         inj_count_r <= 32'd0;
      end else if (inj_valid_r) begin
         inj_count_r <= inj_count_r + 32'd1;
      end else begin
         inj_count_r <= inj_count_r;
      end
   end

   assign o_inj_count = inj_count_r;
`endif

endmodule

// File: tb/tb_force_ring_inject_arbiter.sv
// Directed self-checking bench for force_ring_inject_arbiter (also covers FORCE_INJ_STATS_EN builds).
module tb_force_ring_inject_arbiter;
   import force_ring_inject_arbiter_pkg::*;

   localparam int N = 4;
   localparam int W = FRC_PKT_STRUCT_WIDTH;

   logic           clk = 1'b0;
   logic           rst;
   logic           i_phase_start;
   logic [N-1:0]   i_req_valid;
   logic [N*W-1:0] i_req_pkt;
   logic [N-1:0]   i_req_done;
   logic [N-1:0]   o_req_ready;
   logic [W-1:0]   o_inj_pkt;
   logic           o_inj_valid;
   logic           i_ring_full;
   logic           i_ring_all_empty;
   logic           o_busy;
   logic           o_phase_done;
`ifdef FORCE_INJ_STATS_EN
   logic [31:0]    o_inj_count;
`endif

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   force_ring_inject_arbiter #(.NUM_REQ(N), .DRAIN_QUIET_CYCLES(16)) dut (
      .clk              (clk),
      .rst              (rst),
      .i_phase_start    (i_phase_start),
      .i_req_valid      (i_req_valid),
      .i_req_pkt        (i_req_pkt),
      .i_req_done       (i_req_done),
      .o_req_ready      (o_req_ready),
      .o_inj_pkt        (o_inj_pkt),
      .o_inj_valid      (o_inj_valid),
      .i_ring_full      (i_ring_full),
      .i_ring_all_empty (i_ring_all_empty),
      .o_busy           (o_busy),
      .o_phase_done     (o_phase_done)
`ifdef FORCE_INJ_STATS_EN
      ,
      .o_inj_count      (o_inj_count)
`endif
   );

   function automatic logic [W-1:0] pkt_of(input int k);
      return {8'(k + 1), 8'hC3, 32'hF00D_0000 + 32'(k)};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; i_phase_start = 1'b0; i_req_valid = 4'b0000; i_req_done = 4'b0000;
      i_ring_full = 1'b0; i_ring_all_empty = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic start_phase;
      i_phase_start = 1'b1;
      tick();
      i_phase_start = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      rst = 1'b1;
      tick();
      vectors += 5;
      if (o_inj_valid !== 1'b0) begin miscompares++; $display("FAIL reset_inj_valid: got %b want 0", o_inj_valid); end
      if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      if (o_phase_done !== 1'b0) begin miscompares++; $display("FAIL reset_phase_done: got %b want 0", o_phase_done); end
      if (o_req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready: got %b want 0000", o_req_ready); end
      if (o_inj_pkt !== 48'h0) begin miscompares++; $display("FAIL reset_pkt: got %h want 0", o_inj_pkt); end
      rst = 1'b0;
      i_req_valid = 4'b1111;
      tick();
      vectors++;
      if (o_req_ready !== 4'b0000) begin miscompares++; $display("FAIL idle_no_grant: got %b want 0000", o_req_ready); end
   endtask

   task automatic test_alternate;
      logic [N-1:0] exp_g;
      do_reset();
      i_req_valid = 4'b0101;
      start_phase();
      for (int c = 0; c < 6; c++) begin
         exp_g = (c % 2 == 0) ? 4'b0001 : 4'b0100;
         #1;
         vectors += 2;
         if (o_req_ready !== exp_g) begin miscompares++; $display("FAIL alt_ready[%0d]: got %b want %b", c, o_req_ready, exp_g); end
         if (o_inj_valid !== (c > 0)) begin miscompares++; $display("FAIL alt_inj_valid[%0d]: got %b want %b", c, o_inj_valid, (c > 0)); end
         if (c > 0) begin
            vectors++;
            if (o_inj_pkt !== pkt_of((c % 2 == 0) ? 2 : 0)) begin
               miscompares++; $display("FAIL alt_pkt[%0d]: got %h want %h", c, o_inj_pkt, pkt_of((c % 2 == 0) ? 2 : 0));
            end
         end
         tick();
      end
   endtask

   task automatic test_full_stall;
      logic [N-1:0] exp_ready [8] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0001};
      logic         full_seq  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic         exp_val   [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      int           exp_src   [8] = '{0, 0, 1, 0, 0, 0, 2, 3};
      do_reset();
      i_req_valid = 4'b1111;
      start_phase();
      for (int c = 0; c < 8; c++) begin
         i_ring_full = full_seq[c];
         #1;
         vectors += 2;
         if (o_req_ready !== exp_ready[c]) begin miscompares++; $display("FAIL full_ready[%0d]: got %b want %b", c, o_req_ready, exp_ready[c]); end
         if (o_inj_valid !== exp_val[c]) begin miscompares++; $display("FAIL full_inj_valid[%0d]: got %b want %b", c, o_inj_valid, exp_val[c]); end
         if (exp_val[c]) begin
            vectors++;
            if (o_inj_pkt !== pkt_of(exp_src[c])) begin miscompares++; $display("FAIL full_pkt[%0d]: got %h want %h", c, o_inj_pkt, pkt_of(exp_src[c])); end
         end
         tick();
      end
      i_ring_full = 1'b0;
   endtask

   // drop_at: cycle (relative to last o_inj_valid) where ring_all_empty dips; exp_n: expected done cycle
   task automatic test_drain(input int drop_at, input int exp_n);
      int  cnt [N];
      int  n;
      bit  found;
      do_reset();
      for (int k = 0; k < N; k++) cnt[k] = 0;
      i_req_valid = 4'b1111;
      start_phase();
      for (int t = 0; t < 20; t++) begin
         for (int k = 0; k < N; k++) begin
            i_req_valid[k] = (cnt[k] < 5);
            i_req_done[k]  = (k == t % 4) && (cnt[k] == 4);
         end
         #1;
         vectors++;
         if (o_req_ready !== 4'(1 << (t % 4))) begin
            miscompares++; $display("FAIL drain_ready[%0d]: got %b want %b", t, o_req_ready, 4'(1 << (t % 4)));
         end
         cnt[t % 4]++;
         tick();
      end
      i_req_valid = 4'b0000;
      i_req_done  = 4'b0000;
      n = 0;
      found = 1'b0;
      while (!found && n < 80) begin
         i_ring_all_empty = (n == drop_at) ? 1'b0 : 1'b1;
         #1;
         if (n == 0) begin
            vectors += 2;
            if (o_inj_valid !== 1'b1) begin miscompares++; $display("FAIL drain_last_valid: got %b want 1", o_inj_valid); end
            if (o_inj_pkt !== pkt_of(3)) begin miscompares++; $display("FAIL drain_last_pkt: got %h want %h", o_inj_pkt, pkt_of(3)); end
         end
         if (o_phase_done === 1'b1) found = 1'b1;
         else begin
            tick();
            n++;
         end
      end
      i_ring_all_empty = 1'b1;
      // One cycle to enter DRAIN, DRAIN_QUIET_CYCLES counted cycles, then the DONE cycle.
      vectors += 2;
      if (!found) begin miscompares++; $display("FAIL drain_timeout: got no o_phase_done want pulse at %0d", exp_n); end
      else if (n != exp_n) begin miscompares++; $display("FAIL drain_done_cycle: got %0d want %0d", n, exp_n); end
      if (o_busy !== 1'b1) begin miscompares++; $display("FAIL drain_busy_done: got %b want 1", o_busy); end
`ifdef FORCE_INJ_STATS_EN
      vectors++;
      if (o_inj_count !== 32'd20) begin miscompares++; $display("FAIL stats_count: got %0d want 20", o_inj_count); end
`endif
      tick();
      vectors += 2;
      if (o_phase_done !== 1'b0) begin miscompares++; $display("FAIL drain_done_pulse: got %b want 0", o_phase_done); end
      if (o_busy !== 1'b0) begin miscompares++; $display("FAIL drain_idle_busy: got %b want 0", o_busy); end
`ifdef FORCE_INJ_STATS_EN
      vectors++;
      if (o_inj_count !== 32'd20) begin miscompares++; $display("FAIL stats_hold: got %0d want 20", o_inj_count); end
      start_phase();
      vectors++;
      if (o_inj_count !== 32'd0) begin miscompares++; $display("FAIL stats_clear: got %0d want 0", o_inj_count); end
`endif
   endtask

   task automatic test_reset_mid;
      do_reset();
      i_req_valid = 4'b1111;
      start_phase();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      vectors += 3;
      if (o_inj_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_inj_valid: got %b want 0", o_inj_valid); end
      if (o_busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy: got %b want 0", o_busy); end
      if (o_req_ready !== 4'b0000) begin miscompares++; $display("FAIL mid_rst_ready: got %b want 0000", o_req_ready); end
      tick();
      start_phase();
      #1;
      vectors++;
      if (o_req_ready !== 4'b0001) begin miscompares++; $display("FAIL mid_rst_restart: got %b want 0001", o_req_ready); end
   endtask

   initial begin
      rst = 1'b1; i_phase_start = 1'b0; i_req_valid = 4'b0000; i_req_done = 4'b0000;
      i_ring_full = 1'b0; i_ring_all_empty = 1'b1;
      for (int k = 0; k < N; k++) i_req_pkt[k*W +: W] = pkt_of(k);
      test_reset();
      test_alternate();
      test_full_stall();
      test_drain(-1, 18);
      test_drain(11, 29);
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
